yc_burst_sched: RTL and testbench



---
 rtl/yc_pkg.sv | 31 +++
 rtl/yc_cfg_shadow.sv | 45 ++++
 rtl/yc_burst_sched.sv | 145 ++++++++++++++
 tb/tb_yc_burst_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yc_pkg.sv
// Shared types and constants for the YC encoder line/field sequencer.
package yc_pkg;

  typedef enum logic [1:0] {
    StSync,
    StPorch,
    StBurst,
    StActive
  } burst_state_t;

  typedef struct packed {
    logic [39:0] phase_inc;
    logic        pal_en;
    logic [10:0] burst_start;
    logic [10:0] burst_len;
  } yc_cfg_t;

  localparam logic [39:0] DefaultPhaseInc = 40'd0;
  localparam logic [10:0] DefaultStart    = 11'd40;
  localparam logic [10:0] DefaultLen      = 11'd200;
  localparam logic [10:0] CntMax          = 11'd2047;
  localparam logic [9:0]  LineMax         = 10'd1023;

  // Burst end at 12 bits, clamped to the counter ceiling.
  function automatic logic [10:0] burst_end(input logic [10:0] start, input logic [10:0] len);
    logic [11:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    return sum[11] ? CntMax : sum[10:0];
  endfunction

endpackage

// File: rtl/yc_cfg_shadow.sv
// Config shadow register: valid/ready capture, committed to live only on a field boundary.
module yc_cfg_shadow
  import yc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cfg_valid,
  input  yc_cfg_t cfg_in,
  input  logic    commit,
  output logic    cfg_ready,
  output yc_cfg_t shadow,
  output logic    apply
);

  logic    pending_q, pending_d;
  logic    take;
  yc_cfg_t shadow_q;

  always_comb begin
    cfg_ready = ~pending_q;
    take      = cfg_valid & ~pending_q;
    apply     = commit & pending_q;
    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end else if (take) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      shadow_q  <= '0;
    end else begin
      pending_q <= pending_d;
      if (take) begin
        shadow_q <= cfg_in;
      end
    end
  end

  assign shadow = shadow_q;

endmodule

// File: rtl/yc_burst_sched.sv
// Line/field sequencer: burst and chroma gates, PAL alternation, field-aligned config apply.
module yc_burst_sched
  import yc_pkg::*;
#(
  parameter logic [39:0] DEFAULT_PHASE_INC = DefaultPhaseInc,
  parameter logic [10:0] DEFAULT_START     = DefaultStart,
  parameter logic [10:0] DEFAULT_LEN       = DefaultLen
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [39:0] cfg_phase_inc,
  input  logic        cfg_pal_en,
  input  logic [10:0] cfg_burst_start,
  input  logic [10:0] cfg_burst_len,
  output logic [39:0] phase_inc,
  output logic        pal_en,
  output logic        burst_gate,
  output logic        active_gate,
  output logic        pal_flip,
  output logic        field_start,
  output logic        cfg_applied,
  output logic [9:0]  line_num
);

  burst_state_t state_q, state_d;
  yc_cfg_t      live_q, shadow, cfg_in;
  logic         hsync_d, vsync_d;
  logic         hsync_rise, hsync_fall, vsync_rise;
  logic         apply;
  logic [10:0]  cnt_q, cnt_d;
  logic [10:0]  end_cnt;
  logic         start_ok;
  logic [9:0]   line_num_q;
  logic         pal_flip_q, field_start_q, cfg_applied_q;

  assign hsync_rise = hsync & ~hsync_d;
  assign hsync_fall = ~hsync & hsync_d;
  assign vsync_rise = vsync & ~vsync_d;

  assign cfg_in = {cfg_phase_inc, cfg_pal_en, cfg_burst_start, cfg_burst_len};

  yc_cfg_shadow u_cfg_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_in    (cfg_in),
    .commit    (vsync_rise),
    .cfg_ready (cfg_ready),
    .shadow    (shadow),
    .apply     (apply)
  );

  // The state machine only ever sees the live window.
  assign end_cnt  = burst_end(live_q.burst_start, live_q.burst_len);
  assign start_ok = (live_q.burst_start != CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (hsync) begin
      state_d = StSync;
    end else begin
      case (state_q)
        StSync: begin
          if (hsync_fall) state_d = StPorch;
        end
        StPorch: begin
          if (start_ok && (cnt_q == live_q.burst_start)) begin
            state_d = (live_q.burst_len != 11'd0) ? StBurst : StActive;
          end
        end
        StBurst: begin
          if (cnt_q == end_cnt) state_d = StActive;
        end
        StActive: state_d = StActive;
        default:  state_d = StSync;
      endcase
    end
  end

  always_comb begin
    burst_gate  = (state_q == StBurst);
    active_gate = (state_q == StActive);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hsync || (state_q == StSync)) begin
      cnt_d = 11'd0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_d       <= 1'b0;
      vsync_d       <= 1'b0;
      cnt_q         <= 11'd0;
      line_num_q    <= 10'd0;
      pal_flip_q    <= 1'b0;
      field_start_q <= 1'b0;
      cfg_applied_q <= 1'b0;
      live_q        <= {DEFAULT_PHASE_INC, 1'b0, DEFAULT_START, DEFAULT_LEN};
    end else begin
      hsync_d       <= hsync;
      vsync_d       <= vsync;
      cnt_q         <= cnt_d;
      field_start_q <= vsync_rise;
      cfg_applied_q <= apply;
      if (apply) begin
        live_q <= shadow;
      end
      if (vsync_rise) begin
        line_num_q <= 10'd0;
      end else if (hsync_rise && (line_num_q != LineMax)) begin
        line_num_q <= line_num_q + 10'd1;
      end
      if (vsync_rise || !live_q.pal_en) begin
        pal_flip_q <= 1'b0;
      end else if (hsync_rise) begin
        pal_flip_q <= ~pal_flip_q;
      end
    end
  end

  assign phase_inc   = live_q.phase_inc;
  assign pal_en      = live_q.pal_en;
  assign pal_flip    = pal_flip_q;
  assign field_start = field_start_q;
  assign cfg_applied = cfg_applied_q;
  assign line_num    = line_num_q;

endmodule

// File: tb/tb_yc_burst_sched.sv
// Directed bench for yc_burst_sched with a per-line scoreboard and a config model.
module tb_yc_burst_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync;
  logic        cfg_valid, cfg_ready;
  logic [39:0] cfg_phase_inc;
  logic        cfg_pal_en;
  logic [10:0] cfg_burst_start, cfg_burst_len;
  logic [39:0] phase_inc;
  logic        pal_en, burst_gate, active_gate, pal_flip, field_start, cfg_applied;
  logic [9:0]  line_num;

  always #5 clk = ~clk;

  yc_burst_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsync           (hsync),
    .vsync           (vsync),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_phase_inc   (cfg_phase_inc),
    .cfg_pal_en      (cfg_pal_en),
    .cfg_burst_start (cfg_burst_start),
    .cfg_burst_len   (cfg_burst_len),
    .phase_inc       (phase_inc),
    .pal_en          (pal_en),
    .burst_gate      (burst_gate),
    .active_gate     (active_gate),
    .pal_flip        (pal_flip),
    .field_start     (field_start),
    .cfg_applied     (cfg_applied),
    .line_num        (line_num)
  );

  typedef struct {
    int boff;
    int blen;
    int aoff;
    int alen;
    int ln;
    int pf;
  } line_exp_t;

  line_exp_t   sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Model of live config, shadow and per-field counters.
  logic [39:0] m_pi;
  bit          m_pal;
  int          m_start, m_len;
  logic [39:0] s_pi;
  bit          s_pal;
  int          s_start, s_len;
  bit          m_pend;
  int          m_ln;
  bit          m_pf;
  logic [39:0] o_pi;
  bit          o_pal;
  int          o_start, o_len;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pi = 40'd0; m_pal = 1'b0; m_start = 40; m_len = 200;
    s_pi = 40'd0; s_pal = 1'b0; s_start = 0; s_len = 0;
    m_pend = 1'b0; m_ln = 0; m_pf = 1'b0;
  endtask

  function automatic line_exp_t expect_line(input int st, input int ln, input int lo);
    line_exp_t e;
    int        en;
    e = '{default: 0};
    if (st < 2047) begin
      en = st + ln;
      if (en > 2047) en = 2047;
      if (ln != 0) begin
        e.boff = st + 2;
        e.blen = en - st;
        e.aoff = en + 2;
      end else begin
        e.aoff = st + 2;
      end
      if (e.boff != 0) begin
        if (e.boff > lo) begin
          e.boff = 0;
          e.blen = 0;
        end else if (e.boff + e.blen - 1 > lo) begin
          e.blen = lo - e.boff + 1;
        end
      end
      if (e.aoff > lo) e.aoff = 0;
      else e.alen = lo - e.aoff + 1;
    end
    return e;
  endfunction

  task automatic set_cfg(input logic [39:0] pi, input bit pal, input int st, input int ln);
    o_pi = pi; o_pal = pal; o_start = st; o_len = ln;
    cfg_phase_inc   = pi;
    cfg_pal_en      = pal;
    cfg_burst_start = 11'(st);
    cfg_burst_len   = 11'(ln);
  endtask

  task automatic capture_offer();
    if (!m_pend) begin
      s_pi = o_pi; s_pal = o_pal; s_start = o_start; s_len = o_len;
      m_pend = 1'b1;
    end
  endtask

  task automatic offer_cfg(input string tag);
    cfg_valid = 1'b1;
    step();
    capture_offer();
    cfg_valid = 1'b0;
    check({tag, " cfg_ready"}, 64'(cfg_ready), 64'(!m_pend));
    check({tag, " phase_inc held"}, 64'(phase_inc), 64'(m_pi));
  endtask

  task automatic do_vsync(input string tag, input bit offer);
    bit exp_applied;
    vsync = 1'b1;
    cfg_valid = offer;
    step();
    exp_applied = m_pend;
    if (m_pend) begin
      m_pi = s_pi; m_pal = s_pal; m_start = s_start; m_len = s_len;
      m_pend = 1'b0;
    end
    if (offer) capture_offer();
    m_ln = 0;
    m_pf = 1'b0;
    cfg_valid = 1'b0;
    check({tag, " field_start"}, 64'(field_start), 64'd1);
    check({tag, " cfg_applied"}, 64'(cfg_applied), 64'(exp_applied));
    check({tag, " line_num clr"}, 64'(line_num), 64'd0);
    check({tag, " pal_flip clr"}, 64'(pal_flip), 64'd0);
    check({tag, " phase_inc"}, 64'(phase_inc), 64'(m_pi));
    check({tag, " pal_en"}, 64'(pal_en), 64'(m_pal));
    check({tag, " cfg_ready"}, 64'(cfg_ready), 64'(!m_pend));
    vsync = 1'b0;
    step();
    check({tag, " field_start pulse"}, 64'(field_start), 64'd0);
    check({tag, " cfg_applied pulse"}, 64'(cfg_applied), 64'd0);
  endtask

  task automatic run_line(input string tag, input int hi, input int lo);
    line_exp_t e, o;
    if (m_ln < 1023) m_ln++;
    m_pf = m_pal ? ~m_pf : 1'b0;
    e = expect_line(m_start, m_len, lo);
    e.ln = m_ln;
    e.pf = int'(m_pf);
    sb.push_back(e);
    o = '{default: 0};
    hsync = 1'b1;
    for (int j = 1; j <= hi; j++) begin
      step();
      if (j == 1) begin
        o.ln = int'(line_num);
        o.pf = int'(pal_flip);
        check({tag, " gates low in sync"}, 64'({burst_gate, active_gate}), 64'd0);
      end
      if (burst_gate) o.blen++;
      if (active_gate) o.alen++;
    end
    hsync = 1'b0;
    for (int j = 1; j <= lo; j++) begin
      step();
      if (burst_gate) begin
        if (o.boff == 0) o.boff = j;
        o.blen++;
      end
      if (active_gate) begin
        if (o.aoff == 0) o.aoff = j;
        o.alen++;
      end
    end
    e = sb.pop_front();
    check({tag, " line_num"}, 64'(o.ln), 64'(e.ln));
    check({tag, " pal_flip"}, 64'(o.pf), 64'(e.pf));
    check({tag, " burst_off"}, 64'(o.boff), 64'(e.boff));
    check({tag, " burst_len"}, 64'(o.blen), 64'(e.blen));
    check({tag, " active_off"}, 64'(o.aoff), 64'(e.aoff));
    check({tag, " active_len"}, 64'(o.alen), 64'(e.alen));
    check({tag, " phase_inc"}, 64'(phase_inc), 64'(m_pi));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; cfg_valid = 1'b0;
    set_cfg(40'd0, 1'b0, 0, 0);
    model_reset();
    #23;
    check("reset burst_gate", 64'(burst_gate), 64'd0);
    check("reset active_gate", 64'(active_gate), 64'd0);
    check("reset pal_flip", 64'(pal_flip), 64'd0);
    check("reset field_start", 64'(field_start), 64'd0);
    check("reset cfg_applied", 64'(cfg_applied), 64'd0);
    check("reset line_num", 64'(line_num), 64'd0);
    check("reset cfg_ready", 64'(cfg_ready), 64'd1);
    check("reset phase_inc", 64'(phase_inc), 64'd0);
    check("reset pal_en", 64'(pal_en), 64'd0);
    #9 rst_n = 1'b1;
    step();

    // Default window lines.
    for (int i = 0; i < 3; i++) run_line("dflt", 60, 800);

    // Mid-field config offer; a second offer while pending is ignored.
    set_cfg(40'h1234567890, 1'b1, 40, 200);
    offer_cfg("offer1");
    set_cfg(40'hAAAAAAAAAA, 1'b0, 10, 10);
    offer_cfg("offer busy");
    run_line("pending", 60, 800);
    do_vsync("apply1", 1'b0);

    // PAL alternation across five lines, then vsync clear.
    for (int i = 0; i < 5; i++) run_line("pal", 60, 800);
    do_vsync("pal vsync", 1'b0);

    // Offer coinciding with vsync rise: accepted, applied one field later.
    set_cfg(40'h5, 1'b0, 30, 0);
    do_vsync("vs offer", 1'b1);
    run_line("vs old", 60, 800);
    do_vsync("vs apply", 1'b0);
    run_line("len0", 60, 800);

    // Burst clamped at the counter ceiling.
    set_cfg(40'h77, 1'b0, 2000, 100);
    offer_cfg("clamp");
    do_vsync("clamp apply", 1'b0);
    run_line("clamp", 60, 2100);

    // Start at the ceiling: no burst, no active window.
    set_cfg(40'h78, 1'b0, 2047, 5);
    offer_cfg("st2047");
    do_vsync("st2047 apply", 1'b0);
    run_line("st2047", 60, 2100);

    // hsync returning high mid-burst.
    set_cfg(40'h99, 1'b1, 40, 200);
    offer_cfg("short");
    do_vsync("short apply", 1'b0);
    run_line("short", 60, 100);
    run_line("recover", 60, 800);

    // Asynchronous reset during ACTIVE with a pending shadow.
    set_cfg(40'hDEADBEEF01, 1'b1, 20, 20);
    offer_cfg("pre-reset");
    hsync = 1'b1;
    for (int j = 0; j < 10; j++) step();
    hsync = 1'b0;
    for (int j = 0; j < 300; j++) step();
    check("pre-reset active_gate", 64'(active_gate), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async rst active_gate", 64'(active_gate), 64'd0);
    check("async rst burst_gate", 64'(burst_gate), 64'd0);
    check("async rst cfg_ready", 64'(cfg_ready), 64'd1);
    check("async rst phase_inc", 64'(phase_inc), 64'd0);
    check("async rst pal_en", 64'(pal_en), 64'd0);
    check("async rst line_num", 64'(line_num), 64'd0);
    #3 rst_n = 1'b1;
    step();
    check("post rst cfg_ready", 64'(cfg_ready), 64'd1);
    do_vsync("post rst vsync", 1'b0);
    run_line("post rst", 60, 800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
